// File: rtl/power_gate_ctrl_if.sv
// power_gate_ctrl_if
// Groups the power-manager request lines and the sleep-transistor / status
// lines of power_gate_ctrl into one bundle.
//   master : power manager side (drives sleep_req/wake_req, observes status)
//   slave  : power_gate_ctrl side (observes requests, drives gates/status)
// Signals:
//   sleep_req, wake_req      level requests from the power manager
//   hdr_weak_n, hdr_strong_n pmos header gates, 0 = conducting
//   ftr_en                   nmos footer gate, 1 = conducting
//   iso_en                   isolation clamp enable, 1 = clamped
//   pwr_good                 island fully powered and unclamped
//   busy                     sequencer in a transitional state
//   sleep_done, wake_done    one-cycle completion pulses
interface power_gate_ctrl_if;
   logic sleep_req;
   logic wake_req;
   logic hdr_weak_n;
   logic hdr_strong_n;
   logic ftr_en;
   logic iso_en;
   logic pwr_good;
   logic busy;
   logic sleep_done;
   logic wake_done;

   modport master (
      output sleep_req, wake_req,
      input  hdr_weak_n, hdr_strong_n, ftr_en, iso_en, pwr_good, busy,
             sleep_done, wake_done
   );

   modport slave (
      input  sleep_req, wake_req,
      output hdr_weak_n, hdr_strong_n, ftr_en, iso_en, pwr_good, busy,
             sleep_done, wake_done
   );
endinterface

// File: rtl/power_gate_ctrl.sv
// power_gate_ctrl
// Sequences the sleep transistors of a switch-level logic island: clamps the
// island outputs before cutting the rails, and restores the rails in two
// stages (weak header, then strong header) to limit rush current before
// releasing the clamps.
// Parameters:
//   ISO_CYCLES    cycles isolation is held before the rails are cut (1..255)
//   SETTLE_CYCLES cycles spent in each wake stage (1..255)
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset, returns to ACTIVE
//   pg   power_gate_ctrl_if.slave: requests in, gate/status outputs out
// All outputs are flops loaded from the next-state decode, so no input
// reaches an output without passing through a register.
module power_gate_ctrl #(
   parameter int unsigned ISO_CYCLES    = 2,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   power_gate_ctrl_if.slave pg
);

   typedef enum logic [2:0] {
      ACTIVE,
      ISO,
      SLEEP,
      WAKE_WEAK,
      WAKE_STRONG
   } state_t;

   localparam logic [7:0] ISO_LAST    = 8'(ISO_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;

   // {hdr_weak_n, hdr_strong_n, ftr_en, iso_en, pwr_good, busy}
   logic [5:0] rails_q, rails_nxt;
   logic       sleep_done_q, sleep_done_nxt;
   logic       wake_done_q, wake_done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ACTIVE;
         cnt          <= '0;
         rails_q      <= 6'b001010;
         sleep_done_q <= 1'b0;
         wake_done_q  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         rails_q      <= rails_nxt;
         sleep_done_q <= sleep_done_nxt;
         wake_done_q  <= wake_done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACTIVE: begin
            if (pg.sleep_req) state_nxt = ISO;
         end
         ISO: begin
            // A dropped request aborts before the dwell count is considered.
            if (!pg.sleep_req)        state_nxt = ACTIVE;
            else if (cnt == ISO_LAST) state_nxt = SLEEP;
         end
         SLEEP: begin
            if (pg.wake_req) state_nxt = WAKE_WEAK;
         end
         WAKE_WEAK: begin
            if (cnt == SETTLE_LAST) state_nxt = WAKE_STRONG;
         end
         WAKE_STRONG: begin
            if (cnt == SETTLE_LAST) state_nxt = ACTIVE;
         end
         default: state_nxt = ACTIVE;
      endcase
   end

   always_comb begin
      cnt_nxt = '0;
      if (state_nxt == state && state inside {ISO, WAKE_WEAK, WAKE_STRONG})
         cnt_nxt = cnt + 8'd1;
   end

   // Outputs decoded from the state being entered so they appear in the same
   // cycle as the state itself.
   always_comb begin
      rails_nxt = 6'b001010;
      unique case (state_nxt)
         ACTIVE:      rails_nxt = 6'b001010;
         ISO:         rails_nxt = 6'b001101;
         SLEEP:       rails_nxt = 6'b110100;
         WAKE_WEAK:   rails_nxt = 6'b011101;
         WAKE_STRONG: rails_nxt = 6'b001101;
         default:     rails_nxt = 6'b001010;
      endcase
      sleep_done_nxt = (state_nxt == SLEEP) && (state != SLEEP);
      wake_done_nxt  = (state_nxt == ACTIVE) && (state == WAKE_STRONG);
   end

   assign pg.hdr_weak_n   = rails_q[5];
   assign pg.hdr_strong_n = rails_q[4];
   assign pg.ftr_en       = rails_q[3];
   assign pg.iso_en       = rails_q[2];
   assign pg.pwr_good     = rails_q[1];
   assign pg.busy         = rails_q[0];
   assign pg.sleep_done   = sleep_done_q;
   assign pg.wake_done    = wake_done_q;

endmodule

// File: tb/tb_power_gate_ctrl.sv
// tb_power_gate_ctrl
// Three sequencers with different timing parameters are driven side by side.
// Each cycle the stimulus process advances a behavioural model (phase plus
// remaining-edge timer) and queues the expected outputs; a monitor on the
// falling edge pops and compares, and also checks the rail-ordering
// invariants on every cycle.
module tb_power_gate_ctrl;

   typedef enum int {M_ON, M_CLAMP, M_OFF, M_RAMP1, M_RAMP2} mode_t;

   typedef struct {
      int         inst;
      mode_t      mode;
      logic [7:0] v;
   } exp_t;

   logic       clk = 1'b0;
   logic [2:0] rstv = '1;
   logic [2:0] sreq = '1;
   logic [2:0] wreq = '1;
   logic [7:0] dout [3];
   logic [7:0] prev [3];

   int checks   = 0;
   int failures = 0;

   exp_t  sb_q [$];
   mode_t md [3];
   int    left [3];
   int    iso_p [3] = '{2, 5, 1};
   int    set_p [3] = '{4, 4, 1};

   always #5 clk = ~clk;

   power_gate_ctrl_if if0 ();
   power_gate_ctrl_if if1 ();
   power_gate_ctrl_if if2 ();

   power_gate_ctrl #(.ISO_CYCLES(2), .SETTLE_CYCLES(4)) dut0 (.clk(clk), .rst(rstv[0]), .pg(if0));
   power_gate_ctrl #(.ISO_CYCLES(5), .SETTLE_CYCLES(4)) dut1 (.clk(clk), .rst(rstv[1]), .pg(if1));
   power_gate_ctrl #(.ISO_CYCLES(1), .SETTLE_CYCLES(1)) dut2 (.clk(clk), .rst(rstv[2]), .pg(if2));

   assign if0.sleep_req = sreq[0];
   assign if0.wake_req  = wreq[0];
   assign if1.sleep_req = sreq[1];
   assign if1.wake_req  = wreq[1];
   assign if2.sleep_req = sreq[2];
   assign if2.wake_req  = wreq[2];

   assign dout[0] = {if0.hdr_weak_n, if0.hdr_strong_n, if0.ftr_en, if0.iso_en,
                     if0.pwr_good, if0.busy, if0.sleep_done, if0.wake_done};
   assign dout[1] = {if1.hdr_weak_n, if1.hdr_strong_n, if1.ftr_en, if1.iso_en,
                     if1.pwr_good, if1.busy, if1.sleep_done, if1.wake_done};
   assign dout[2] = {if2.hdr_weak_n, if2.hdr_strong_n, if2.ftr_en, if2.iso_en,
                     if2.pwr_good, if2.busy, if2.sleep_done, if2.wake_done};

   // {hdr_weak_n, hdr_strong_n, ftr_en, iso_en, pwr_good, busy} per phase
   function automatic logic [5:0] rails_of(input mode_t m);
      case (m)
         M_ON:    return 6'b001010;
         M_CLAMP: return 6'b001101;
         M_OFF:   return 6'b110100;
         M_RAMP1: return 6'b011101;
         default: return 6'b001101;
      endcase
   endfunction

   // Advance the model of instance i by one rising edge.
   task automatic model_step(input int i);
      logic sd = 1'b0;
      logic wd = 1'b0;
      exp_t e;
      if (rstv[i]) begin
         md[i]   = M_ON;
         left[i] = 0;
      end else begin
         case (md[i])
            M_ON: if (sreq[i]) begin md[i] = M_CLAMP; left[i] = iso_p[i]; end
            M_CLAMP: begin
               if (!sreq[i]) md[i] = M_ON;
               else begin
                  left[i]--;
                  if (left[i] == 0) begin md[i] = M_OFF; sd = 1'b1; end
               end
            end
            M_OFF: if (wreq[i]) begin md[i] = M_RAMP1; left[i] = set_p[i]; end
            M_RAMP1: begin
               left[i]--;
               if (left[i] == 0) begin md[i] = M_RAMP2; left[i] = set_p[i]; end
            end
            default: begin
               left[i]--;
               if (left[i] == 0) begin md[i] = M_ON; wd = 1'b1; end
            end
         endcase
      end
      e.inst = i;
      e.mode = md[i];
      e.v    = {rails_of(md[i]), sd, wd};
      sb_q.push_back(e);
   endtask

   // Queue expectations for the coming edge, then move to just after the
   // following falling edge so new inputs never race the clock.
   task automatic tick();
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      #1;
   endtask

   task automatic drive_all(input logic r, input logic s, input logic w, input int n);
      rstv = {3{r}};
      sreq = {3{s}};
      wreq = {3{w}};
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string name, input int i, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s[%0d] t=%0t got=%b required=%b", name, i, $time, got, req);
      end
   endtask

   task automatic compare(input exp_t e);
      logic [7:0] a;
      a = dout[e.inst];
      chk("outputs", e.inst, a, e.v);
      if (a[7] || a[6] || !a[5]) chk("inv_iso_when_off", e.inst, {7'd0, a[4]}, 8'd1);
      chk("inv_pwr_good_only_active", e.inst, {7'd0, a[3]}, {7'd0, e.mode == M_ON});
      if (!a[6]) chk("inv_strong_implies_weak", e.inst, {7'd0, a[7]}, 8'd0);
      if (!a[7] || !a[6]) chk("inv_footer_with_header", e.inst, {7'd0, a[5]}, 8'd1);
      if (a[1]) chk("iso_before_sleep", e.inst, {2'b00, prev[e.inst][7:2]}, 8'b00001101);
      prev[e.inst] = a;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compare(e);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         md[i]   = M_ON;
         left[i] = 0;
         prev[i] = '0;
      end

      // Reset with both requests high, then release: sleep wins.
      drive_all(1'b1, 1'b1, 1'b1, 3);
      drive_all(1'b0, 1'b1, 1'b1, 1);
      // Immediate abort from ISO.
      drive_all(1'b0, 1'b0, 1'b0, 4);
      // Sleep held 3 edges: ISO_CYCLES=2 reaches SLEEP, ISO_CYCLES=5 aborts.
      drive_all(1'b0, 1'b1, 1'b0, 3);
      drive_all(1'b0, 1'b0, 1'b0, 5);
      // Wake, with sleep re-requested mid-wake and held past ACTIVE.
      drive_all(1'b0, 1'b0, 1'b1, 1);
      drive_all(1'b0, 1'b0, 1'b0, 1);
      drive_all(1'b0, 1'b1, 1'b0, 12);
      drive_all(1'b0, 1'b0, 1'b0, 2);
      // Reset in a wake stage, then reset while asleep.
      drive_all(1'b0, 1'b1, 1'b0, 7);
      drive_all(1'b0, 1'b0, 1'b1, 2);
      drive_all(1'b1, 1'b0, 1'b0, 1);
      drive_all(1'b0, 1'b0, 1'b0, 2);
      drive_all(1'b0, 1'b1, 1'b0, 8);
      drive_all(1'b1, 1'b0, 1'b0, 1);
      drive_all(1'b0, 1'b0, 1'b0, 3);

      // Random phase: requests toggle occasionally so long dwells still occur.
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 3; i++) begin
            rstv[i] = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 4) == 0) sreq[i] = ~sreq[i];
            if ($urandom_range(0, 3) == 0) wreq[i] = ~wreq[i];
         end
         tick();
      end

      for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
      if (sb_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain got=%0d pending required=0", sb_q.size());
      end
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
